piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in/serial-out transmitter that feeds our serial-to-parallel receive register. It accepts a SIZE-bit word through a valid/ready load handshake, then emits it MSB-first, one bit per enabled cycle. For each bit it drives a serial data line and a one-cycle shift strobe that connect directly to the receiver's `s_in` and `shift` inputs. After SIZE strobes the receiver's parallel output equals the loaded word.

## Interface
- `SIZE`, default 256: word width in bits; must be ≥ 2.
- `CNT_W`, local, `$clog2(SIZE)`: bit-counter width; not overridable.

Ports:
- `clk` (in, 1): clock.
- `reset` (in, 1): asynchronous reset, active-high.
- `load_valid` (in, 1): a word is offered on `p_in`.
- `load_ready` (out, 1): block can accept a word. Equals `state == IDLE`.
- `p_in` (in, SIZE): parallel word; sampled only on the accept edge.
- `bit_en` (in, 1): bit-pacing enable; one bit is sent per cycle with `bit_en` high while in SHIFT.
- `s_out` (out, 1): serial data, always the current MSB of the shift register.
- `shift_out` (out, 1): shift strobe, high for each cycle in which `s_out` is valid and must be captured.
- `busy` (out, 1): high in SHIFT and DONE.
- `done` (out, 1): one-cycle pulse after the last bit.

## Operation
- State machine has three states: IDLE, SHIFT, DONE.
- **Reset** (asynchronous):
  - state = IDLE, `shreg` = 0, `cnt` = 0.
  - Outputs: `s_out` = 0, `shift_out` = 0, `busy` = 0, `done` = 0, `load_ready` = 1.
- **IDLE**:
  - Accept occurs when `load_valid` and `load_ready` are both high at a clock edge.
  - On accept: `shreg` ← `p_in`, `cnt` ← 0, next state SHIFT.
  - `p_in` is ignored in every other state.
- **SHIFT**:
  - `shift_out` = `bit_en` (combinational).
  - `s_out` = `shreg[SIZE-1]` (combinational).
  - On an edge with `bit_en` = 1: `shreg` ← `shreg << 1` with LSB filled with 0, and `cnt` ← `cnt + 1`.
  - If `cnt == SIZE-1` on an edge with `bit_en` = 1: next state DONE.
  - With `bit_en` = 0: `shreg` and `cnt` hold and `shift_out` = 0 (stall of any length).
- **DONE**:
  - `done` = 1 for exactly one cycle.
  - `shift_out` = 0 and `s_out` = 0, because `shreg` is empty by then.
  - Next state IDLE unconditionally.
- **Bit order**: `p_in[SIZE-1]` is sent first and `p_in[0]` last. This matches a receiver that shifts left and inserts at bit 0.
- **Counter**: `cnt` never exceeds SIZE-1 and does not wrap.
- **`load_valid` outside IDLE**: ignored, and the in-flight word is not corrupted. The offering side must hold `load_valid` until `load_ready`.
- **Reset mid-transfer**: transfer is aborted immediately, all outputs go to their reset values, and no `done` pulse is produced. The receiver must be reset alongside.

## Timing
- Accept edge E0 → SHIFT from cycle 1. The first `shift_out` appears in the first SHIFT cycle with `bit_en` = 1.
- With `bit_en` tied high:
  - Bits are sent in cycles 1..SIZE.
  - `done` is high in cycle SIZE+1.
  - `load_ready` returns in cycle SIZE+2.
  - Minimum word period is SIZE+2 cycles.
- The receiver samples `s_out` on the same rising edge at which `shreg` shifts; there is no extra pipeline stage.
- `load_ready`, `busy`, `done`, `shift_out` and `s_out` are combinational from state, `shreg` and `bit_en` only. They never depend on `load_valid` or `p_in`, so no combinational loop can form.

## Test plan
- **Reset values**: assert `reset` mid-cycle → `load_ready` = 1, `busy` = `done` = `shift_out` = `s_out` = 0 asynchronously.
- **Basic transfer** (SIZE = 8, `bit_en` = 1, load 8'hA5) → `s_out` sequence under `shift_out` is 1,0,1,0,0,1,0,1 in cycles 1..8; `done` in cycle 9; `load_ready` in cycle 10.
- **Stalls** (SIZE = 8, load 8'h3C, `bit_en` pattern 1,0,0,1,...) → `shift_out` is high only with `bit_en`, bits are 0,0,1,1,1,1,0,0, and `done` follows the 8th strobe by one cycle.
- **Busy load** (load 8'hF0, then hold `load_valid` with `p_in` = 8'h0F during SHIFT) → serial stream still 8'hF0; 8'h0F is accepted only in the cycle after `done`.
- **Reset mid-transfer** (`reset` after 3 bits) → outputs reset, no `done`; a new load of 8'h81 then transfers correctly.
- **Loopback** (SIZE = 256, connected to the receive register with `reset` shared, load 256'h1578…55ad) → receiver parallel output equals the loaded word on the cycle `done` is high.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for the PISO serializer.
// The master side offers words and paces bits; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int SIZE = 256
);
    logic            load_valid;
    logic            load_ready;
    logic [SIZE-1:0] p_in;
    logic            bit_en;
    logic            s_out;
    logic            shift_out;
    logic            busy;
    logic            done;

    modport master (
        output load_valid,
        output p_in,
        output bit_en,
        input  load_ready,
        input  s_out,
        input  shift_out,
        input  busy,
        input  done
    );

    modport slave (
        input  load_valid,
        input  p_in,
        input  bit_en,
        output load_ready,
        output s_out,
        output shift_out,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. Accepts a SIZE-bit word through a
// valid/ready handshake and emits it MSB-first, one bit per enabled cycle,
// with a shift strobe that drives a left-shifting receive register directly.
// Outputs are combinational from state, shift register and bit_en only, so
// they never depend on load_valid or p_in.
module piso_serializer #(
    parameter int SIZE = 256
) (
    input  logic                clk,
    input  logic                reset,
    piso_serializer_if.slave    bus
);
    localparam int CNT_W = $clog2(SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [SIZE-1:0]   shreg_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              accept_s;
    logic              last_bit_s;

    // A word is taken only while idle, so a held load_valid cannot disturb a word in flight.
    assign accept_s   = (state_r == IDLE) && bus.load_valid;
    assign last_bit_s = (cnt_r == CNT_LAST) && bus.bit_en;

    // State register with asynchronous abort back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: DONE follows the last enabled bit, then returns to IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Shift register and bit counter: load on accept, shift left on each enabled bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shreg_r <= bus.p_in;
                        cnt_r   <= '0;
                    end else begin
                        shreg_r <= shreg_r;
                        cnt_r   <= cnt_r;
                    end
                end
                SHIFT: begin
                    if (bus.bit_en) begin
                        shreg_r <= {shreg_r[SIZE-2:0], 1'b0};
                        // Counter saturates at the last bit index instead of wrapping.
                        if (cnt_r != CNT_LAST) begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end else begin
                        shreg_r <= shreg_r;
                        cnt_r   <= cnt_r;
                    end
                end
                default: begin
                    shreg_r <= shreg_r;
                    cnt_r   <= cnt_r;
                end
            endcase
        end
    end

    // Output decode from state, shift register MSB and bit_en.
    always_comb begin
        bus.load_ready = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.shift_out  = 1'b0;
        bus.s_out      = 1'b0;
        case (state_r)
            IDLE: begin
                bus.load_ready = 1'b1;
            end
            SHIFT: begin
                bus.busy      = 1'b1;
                bus.shift_out = bus.bit_en;
                bus.s_out     = shreg_r[SIZE-1];
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
                bus.load_ready = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an 8-bit instance for handshake, stall,
// busy-load and reset-abort behaviour, and a 256-bit instance looped back into
// a left-shifting receive register.
module tb_piso_serializer;
    logic clk;
    logic reset;
    int   checks_total;
    int   fail_cnt;
    int   strobes;
    int   n;
    logic [255:0] rx_r;

    localparam logic [255:0] WORD256 =
        256'h15780123_456789ab_cdef0011_22334455_66778899_aabbccdd_eeff0f1e_2d3c55ad;

    // Expected serial sequences, written in transmission order (first bit at index 7).
    logic [7:0] seq_a5;
    logic [7:0] seq_3c;
    logic [7:0] seq_f0;
    logic [7:0] seq_0f;
    logic [7:0] seq_81;

    piso_serializer_if #(.SIZE(8))   if8();
    piso_serializer_if #(.SIZE(256)) if256();

    piso_serializer #(.SIZE(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    piso_serializer #(.SIZE(256)) dut256 (
        .clk   (clk),
        .reset (reset),
        .bus   (if256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receive register model: shifts left and inserts at bit 0 on each strobe.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_r <= '0;
        end else if (if256.shift_out) begin
            rx_r <= {rx_r[254:0], if256.s_out};
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks_total++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_total = 0;
        fail_cnt     = 0;
        seq_a5 = 8'b1010_0101;
        seq_3c = 8'b0011_1100;
        seq_f0 = 8'b1111_0000;
        seq_0f = 8'b0000_1111;
        seq_81 = 8'b1000_0001;

        reset = 1'b1;
        if8.load_valid   = 1'b0;
        if8.p_in         = 8'h00;
        if8.bit_en       = 1'b0;
        if256.load_valid = 1'b0;
        if256.p_in       = '0;
        if256.bit_en     = 1'b0;

        // Reset values
        #3;
        check("rst_load_ready", if8.load_ready, 1'b1);
        check("rst_busy",       if8.busy,       1'b0);
        check("rst_done",       if8.done,       1'b0);
        check("rst_shift_out",  if8.shift_out,  1'b0);
        check("rst_s_out",      if8.s_out,      1'b0);
        tick();
        reset = 1'b0;

        // Basic transfer of 8'hA5 with bit_en tied high
        if8.load_valid = 1'b1;
        if8.p_in       = 8'hA5;
        if8.bit_en     = 1'b1;
        check("basic_ready_before", if8.load_ready, 1'b1);
        tick();
        if8.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("basic_strobe", if8.shift_out, 1'b1);
            check("basic_bit",    if8.s_out,     seq_a5[7-i]);
            check("basic_busy",   if8.busy,      1'b1);
            tick();
        end
        check("basic_done",        if8.done,       1'b1);
        check("basic_done_strobe", if8.shift_out,  1'b0);
        check("basic_done_sout",   if8.s_out,      1'b0);
        check("basic_done_ready",  if8.load_ready, 1'b0);
        tick();
        check("basic_ready_back",  if8.load_ready, 1'b1);
        check("basic_done_pulse",  if8.done,       1'b0);
        check("basic_idle_busy",   if8.busy,       1'b0);

        // Stalls: load 8'h3C, bit_en high on every third cycle
        if8.load_valid = 1'b1;
        if8.p_in       = 8'h3C;
        tick();
        if8.load_valid = 1'b0;
        strobes = 0;
        for (int c = 0; c < 40 && strobes < 8; c++) begin
            if8.bit_en = (c % 3 == 0);
            #1;
            check("stall_strobe", if8.shift_out, (c % 3 == 0));
            check("stall_busy",   if8.busy,      1'b1);
            if (c % 3 == 0) begin
                check("stall_bit", if8.s_out, seq_3c[7-strobes]);
                strobes++;
            end
            tick();
        end
        check("stall_strobe_count", strobes, 8);
        check("stall_done", if8.done, 1'b1);
        if8.bit_en = 1'b1;
        tick();
        check("stall_ready_back", if8.load_ready, 1'b1);

        // Busy load: 8'hF0 in flight while 8'h0F is held on the port
        if8.load_valid = 1'b1;
        if8.p_in       = 8'hF0;
        tick();
        if8.p_in = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            check("busy_bit",   if8.s_out,      seq_f0[7-i]);
            check("busy_ready", if8.load_ready, 1'b0);
            tick();
        end
        check("busy_done",       if8.done,       1'b1);
        check("busy_done_ready", if8.load_ready, 1'b0);
        tick();
        check("busy_accept_cycle", if8.load_ready, 1'b1);
        tick();
        if8.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("second_bit",  if8.s_out,     seq_0f[7-i]);
            check("second_busy", if8.busy,      1'b1);
            tick();
        end
        check("second_done", if8.done, 1'b1);
        tick();

        // Reset mid-transfer after 3 bits of 8'hFF
        if8.load_valid = 1'b1;
        if8.p_in       = 8'hFF;
        tick();
        if8.load_valid = 1'b0;
        tick();
        tick();
        tick();
        check("abort_pre_bit", if8.s_out, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_load_ready", if8.load_ready, 1'b1);
        check("abort_busy",       if8.busy,       1'b0);
        check("abort_done",       if8.done,       1'b0);
        check("abort_shift_out",  if8.shift_out,  1'b0);
        check("abort_s_out",      if8.s_out,      1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", if8.done,       1'b0);
            check("abort_idle",    if8.load_ready, 1'b1);
            tick();
        end
        if8.load_valid = 1'b1;
        if8.p_in       = 8'h81;
        tick();
        if8.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("reload_strobe", if8.shift_out, 1'b1);
            check("reload_bit",    if8.s_out,     seq_81[7-i]);
            tick();
        end
        check("reload_done", if8.done, 1'b1);
        tick();
        check("reload_ready", if8.load_ready, 1'b1);

        // Loopback of a 256-bit word into the receive register model
        if256.load_valid = 1'b1;
        if256.p_in       = WORD256;
        if256.bit_en     = 1'b1;
        tick();
        if256.load_valid = 1'b0;
        check("loop_busy", if256.busy, 1'b1);
        n = 1;
        while (!if256.done && n < 300) begin
            tick();
            n++;
        end
        check("loop_done_seen",  if256.done, 1'b1);
        check("loop_done_cycle", n, 257);
        check("loop_rx_word",    rx_r, WORD256);
        tick();
        check("loop_ready_back", if256.load_ready, 1'b1);
        check("loop_done_pulse", if256.done, 1'b0);

        $display("%0d/%0d checks passed", checks_total - fail_cnt, checks_total);
        $finish;
    end
endmodule
